// File: rtl/tx_symbol_scheduler_if.sv
// Link-layer and encoder-facing signals of the transmit symbol scheduler.
// master = link layer + encoder side, slave = scheduler.
interface tx_symbol_scheduler_if;
   logic       tx_enable_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic [7:0] tx_data_i;
   logic       tx_k_i;
   logic       tx_start_i;
   logic       tx_end_i;
   logic       sym_valid_o;
   logic [7:0] sym_data_o;
   logic       sym_k_o;
   logic       rd_neg_o;
   logic       enc_rd_neg_post_i;
   logic       skp_active_o;
   logic       skp_overrun_o;

   modport master (
      output tx_enable_i, tx_valid_i, tx_data_i, tx_k_i, tx_start_i, tx_end_i, enc_rd_neg_post_i,
      input  tx_ready_o, sym_valid_o, sym_data_o, sym_k_o, rd_neg_o, skp_active_o, skp_overrun_o
   );

   modport slave (
      input  tx_enable_i, tx_valid_i, tx_data_i, tx_k_i, tx_start_i, tx_end_i, enc_rd_neg_post_i,
      output tx_ready_o, sym_valid_o, sym_data_o, sym_k_o, rd_neg_o, skp_active_o, skp_overrun_o
   );
endinterface

// File: rtl/tx_symbol_scheduler.sv
// Per-symbol sequencer for the 8b/10b encoder: link-layer bytes, idle fill, SKP ordered sets
// inserted between packets, and the running-disparity register.
module tx_symbol_scheduler #(
   parameter int unsigned SKP_INTERVAL = 1180,
   parameter int unsigned NUM_SKP      = 3,
   parameter logic [7:0]  IDLE_BYTE    = 8'h00
) (
   input logic                  clk_i,
   input logic                  reset_i,
   tx_symbol_scheduler_if.slave bus
);
   localparam int unsigned CntW = $clog2(SKP_INTERVAL);
   localparam int unsigned IdxW = $clog2(NUM_SKP + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(SKP_INTERVAL - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_SKP - 1);
   localparam logic [7:0] ComByte = 8'hBC;
   localparam logic [7:0] SkpByte = 8'h1C;

   // StNormal also issues the COM of an ordered set; StSkp issues the NUM_SKP SKP symbols.
   typedef enum logic [0:0] {StNormal, StSkp} state_e;

   state_e          state_q;
   logic [CntW-1:0] skp_cnt_q;
   logic [IdxW-1:0] skp_idx_q;
   logic            skp_pending_q;
   logic            in_pkt_q;
   logic            sym_valid_q;
   logic [7:0]      sym_data_q;
   logic            sym_k_q;
   logic            rd_neg_q;
   logic            skp_active_q;
   logic            skp_overrun_q;

   logic skp_due;
   logic tx_ready;
   logic accept;

   always_comb begin
      skp_due  = skp_pending_q && !in_pkt_q;
      tx_ready = !reset_i && bus.tx_enable_i && (state_q == StNormal) && !skp_due;
      accept   = bus.tx_valid_i && tx_ready;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StNormal;
         skp_cnt_q     <= '0;
         skp_idx_q     <= '0;
         skp_pending_q <= 1'b0;
         in_pkt_q      <= 1'b0;
         sym_valid_q   <= 1'b0;
         sym_data_q    <= 8'h00;
         sym_k_q       <= 1'b0;
         rd_neg_q      <= 1'b1;
         skp_active_q  <= 1'b0;
         skp_overrun_q <= 1'b0;
      end else if (!bus.tx_enable_i) begin
         // Electrical idle: everything holds except valid and RD.
         sym_valid_q <= 1'b0;
         rd_neg_q    <= 1'b1;
      end else begin
         sym_valid_q <= 1'b1;
         if (sym_valid_q) begin
            rd_neg_q <= bus.enc_rd_neg_post_i;
         end
         unique case (state_q)
            StNormal: begin
               if (skp_due) begin
                  sym_data_q    <= ComByte;
                  sym_k_q       <= 1'b1;
                  skp_active_q  <= 1'b1;
                  skp_pending_q <= 1'b0;
                  skp_idx_q     <= '0;
                  state_q       <= StSkp;
               end else begin
                  skp_active_q <= 1'b0;
                  if (accept) begin
                     sym_data_q <= bus.tx_data_i;
                     sym_k_q    <= bus.tx_k_i;
                     if (bus.tx_end_i) begin
                        in_pkt_q <= 1'b0;
                     end else if (bus.tx_start_i) begin
                        in_pkt_q <= 1'b1;
                     end
                  end else begin
                     sym_data_q <= IDLE_BYTE;
                     sym_k_q    <= 1'b0;
                  end
                  if (skp_cnt_q == CntMax) begin
                     skp_cnt_q     <= '0;
                     skp_pending_q <= 1'b1;
                     if (skp_pending_q) begin
                        skp_overrun_q <= 1'b1;
                     end
                  end else begin
                     skp_cnt_q <= skp_cnt_q + CntW'(1);
                  end
               end
            end
            StSkp: begin
               sym_data_q   <= SkpByte;
               sym_k_q      <= 1'b1;
               skp_active_q <= 1'b1;
               if (skp_idx_q == IdxLast) begin
                  skp_idx_q <= '0;
                  state_q   <= StNormal;
               end else begin
                  skp_idx_q <= skp_idx_q + IdxW'(1);
               end
            end
            default: state_q <= StNormal;
         endcase
      end
   end

   assign bus.tx_ready_o    = tx_ready;
   assign bus.sym_valid_o   = sym_valid_q;
   assign bus.sym_data_o    = sym_data_q;
   assign bus.sym_k_o       = sym_k_q;
   assign bus.rd_neg_o      = rd_neg_q;
   assign bus.skp_active_o  = skp_active_q;
   assign bus.skp_overrun_o = skp_overrun_q;
endmodule
